modred_radix: RTL and testbench

- Parametrised, fixed-latency successor to the team's serial modulus reducer.
- Computes quotient and remainder of a 2*WIDTH-bit dividend by a WIDTH-bit modulus using restoring division, RADIX_BITS quotient bits per cycle.
- Optional mode forms the WIDTH x WIDTH product first, giving a (a*b) mod m primitive for the key-generation and exponentiation datapath.
- Flags a zero modulus instead of returning garbage.

---
 rtl/modred_radix_if.sv | 30 +++
 rtl/modred_radix.sv | 161 ++++++++++++++++
 tb/tb_modred_radix.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/modred_radix_if.sv
`default_nettype none
// ============================================================================
// Module   : modred_radix_if
// Purpose  : start/operand/result bundle for the modred_radix reducer
// Revision : 1.0
// ============================================================================
interface modred_radix_if #(
    parameter int WIDTH = 16
) ();
    logic                   ready_in;
    logic                   op_in;
    logic [2*WIDTH-1:0]     value_in;
    logic [WIDTH-1:0]       modulus_in;
    logic [WIDTH-1:0]       remainder_out;
    logic [2*WIDTH-1:0]     quotient_out;
    logic                   busy_out;
    logic                   valid_out;
    logic                   error_out;

    modport master (
        output ready_in, op_in, value_in, modulus_in,
        input  remainder_out, quotient_out, busy_out, valid_out, error_out
    );

    modport slave (
        input  ready_in, op_in, value_in, modulus_in,
        output remainder_out, quotient_out, busy_out, valid_out, error_out
    );
endinterface
`default_nettype wire

// File: rtl/modred_radix.sv
`default_nettype none
// ============================================================================
// Module   : modred_radix
// Purpose  : fixed-latency restoring divider, RADIX_BITS quotient bits/cycle,
//            with optional a*b pre-multiply for (a*b) mod m
// Revision : 1.0
// ============================================================================
module modred_radix #(
    parameter int WIDTH      = 16,
    parameter int RADIX_BITS = 2
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    modred_radix_if.slave   bus
);
    localparam int DW    = 2 * WIDTH;
    localparam int TW    = WIDTH + RADIX_BITS;
    localparam int STEPS = DW / RADIX_BITS;
    localparam int NUM_K = 1 << RADIX_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4 || RADIX_BITS == 8)
            || ((DW % RADIX_BITS) != 0)) begin : g_bad_radix
            $error("modred_radix: RADIX_BITS must be 1, 2, 4 or 8 and divide 2*WIDTH");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [DW-1:0]     d_q, d_d;
    logic [TW-1:0]     r_q, r_d;
    logic [DW-1:0]     q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [DW-1:0]     quot_q, quot_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [DW-1:0]          prod_w;
    logic [TW-1:0]          m_ext_w;
    logic [TW-1:0]          t_w;
    logic [TW-1:0]          mult_w [NUM_K];
    logic [RADIX_BITS-1:0]  k_w;
    logic [TW-1:0]          km_w;
    logic [TW-1:0]          diff_w;

    assign prod_w  = DW'(bus.value_in[WIDTH-1:0]) * DW'(bus.value_in[DW-1:WIDTH]);
    assign m_ext_w = TW'(m_q);
    assign t_w     = (r_q << RADIX_BITS) | TW'(d_q[DW-1 -: RADIX_BITS]);

    // All candidate multiples k*m are formed in parallel; r < m keeps them in TW bits.
    generate
        for (genvar gk = 0; gk < NUM_K; gk++) begin : g_mult
            assign mult_w[gk] = TW'(gk) * m_ext_w;
        end
    endgenerate

    // Multiples are monotonic, so the last passing compare is the largest k.
    always_comb begin
        k_w  = '0;
        km_w = '0;
        for (int k = 1; k < NUM_K; k++) begin
            if (t_w >= mult_w[k]) begin
                k_w  = RADIX_BITS'(k);
                km_w = mult_w[k];
            end
        end
    end

    assign diff_w = t_w - km_w;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ready_in) begin
                    m_d    = bus.modulus_in;
                    d_d    = bus.op_in ? prod_w : bus.value_in;
                    r_d    = '0;
                    q_d    = '0;
                    cnt_d  = CW'(STEPS - 1);
                    busy_d = 1'b1;
                    state_d = (bus.modulus_in == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                d_d = d_q << RADIX_BITS;
                r_d = diff_w;
                q_d = (q_q << RADIX_BITS) | DW'(k_w);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                // r and q were cleared on acceptance, so a zero modulus reports zeros.
                rem_d   = r_q[WIDTH-1:0];
                quot_d  = q_q;
                err_d   = (m_q == '0);
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.remainder_out = rem_q;
    assign bus.quotient_out  = quot_q;
    assign bus.busy_out      = busy_q;
    assign bus.valid_out     = valid_q;
    assign bus.error_out     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_modred_radix.sv
`default_nettype none
// ============================================================================
// Module   : tb_modred_radix
// Purpose  : directed checks on the default reducer plus random sweeps of
//            several WIDTH/RADIX_BITS builds against a plain-arithmetic model
// Revision : 1.0
// ============================================================================
module tb_modred_radix;
    localparam int MAIN_STEPS = 16;
    localparam int N_SWEEP    = 200;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_sw;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    modred_radix_if #(.WIDTH(16)) m_bus ();
    modred_radix #(.WIDTH(16), .RADIX_BITS(2)) u_dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (m_bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: quotient/remainder straight from integer division.
    task automatic model(input bit op, input logic [63:0] val, input logic [63:0] m, input int w,
                         output logic [63:0] eq, output logic [63:0] er, output logic ee);
        longint unsigned mask_w, mask_d, a, b, d;
        mask_w = (64'd1 << w) - 64'd1;
        mask_d = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        a = val & mask_w;
        b = (val >> w) & mask_w;
        d = op ? a * b : (val & mask_d);
        if (m == 64'd0) begin
            eq = '0; er = '0; ee = 1'b1;
        end else begin
            eq = d / m; er = d % m; ee = 1'b0;
        end
    endtask

    task automatic run_main(input string tag, input bit op, input logic [31:0] val,
                            input logic [15:0] m, input int poke_at);
        logic [63:0] eq, er;
        logic        ee;
        int          lat, busy_n, exp_lat;
        model(op, {32'd0, val}, {48'd0, m}, 16, eq, er, ee);
        exp_lat = ee ? 2 : MAIN_STEPS + 2;
        @(negedge clk);
        m_bus.ready_in   = 1'b1;
        m_bus.op_in      = op;
        m_bus.value_in   = val;
        m_bus.modulus_in = m;
        @(posedge clk);
        #1;
        lat    = 1;
        busy_n = int'(m_bus.busy_out);
        m_bus.ready_in   = 1'b0;
        m_bus.op_in      = ~op;
        m_bus.value_in   = $urandom;
        m_bus.modulus_in = 16'($urandom);
        while (!m_bus.valid_out && lat < 200) begin
            m_bus.ready_in = (lat == poke_at);
            @(posedge clk);
            #1;
            lat++;
            busy_n += int'(m_bus.busy_out);
        end
        m_bus.ready_in = 1'b0;
        check_eq({tag, ".lat"},  64'(lat), 64'(exp_lat));
        check_eq({tag, ".busy"}, 64'(busy_n), 64'(exp_lat - 1));
        check_eq({tag, ".quot"}, 64'(m_bus.quotient_out), eq);
        check_eq({tag, ".rem"},  64'(m_bus.remainder_out), er);
        check_eq({tag, ".err"},  64'(m_bus.error_out), 64'(ee));
        @(posedge clk);
        #1;
        check_eq({tag, ".pulse"}, 64'(m_bus.valid_out), 64'd0);
    endtask

    task automatic back_to_back();
        int cyc, n_seen, t_last;
        @(negedge clk);
        m_bus.ready_in   = 1'b1;
        m_bus.op_in      = 1'b0;
        m_bus.value_in   = 32'd1000;
        m_bus.modulus_in = 16'd7;
        cyc = 0; n_seen = 0; t_last = 0;
        while (n_seen < 3 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (m_bus.valid_out) begin
                check_eq("b2b.quot", 64'(m_bus.quotient_out), 64'd142);
                if (n_seen > 0) check_eq("b2b.gap", 64'(cyc - t_last), 64'(MAIN_STEPS + 2));
                t_last = cyc;
                n_seen++;
            end
        end
        m_bus.ready_in = 1'b0;
        check_eq("b2b.count", 64'(n_seen), 64'd3);
    endtask

    task automatic reset_mid_run();
        int seen;
        @(negedge clk);
        m_bus.ready_in   = 1'b1;
        m_bus.op_in      = 1'b0;
        m_bus.value_in   = 32'hDEAD_BEEF;
        m_bus.modulus_in = 16'h1234;
        @(posedge clk);
        #1;
        m_bus.ready_in = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid.busy",  64'(m_bus.busy_out), 64'd0);
        check_eq("rstmid.valid", 64'(m_bus.valid_out), 64'd0);
        check_eq("rstmid.rem",   64'(m_bus.remainder_out), 64'd0);
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
            seen += int'(m_bus.valid_out);
        end
        check_eq("rstmid.novalid", 64'(seen), 64'd0);
    endtask

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_sweep
            localparam int W  = (gi < 3) ? 16 : 32;
            localparam int RB = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 4 : 8);
            localparam int ST = 2 * W / RB;
            bit done = 1'b0;

            modred_radix_if #(.WIDTH(W)) s_bus ();
            modred_radix #(.WIDTH(W), .RADIX_BITS(RB)) u_dut (
                .clk_in   (clk),
                .rst_n_in (rst_n_sw),
                .bus      (s_bus)
            );

            initial begin
                logic [63:0] val, eq, er;
                logic [31:0] m;
                logic        ee;
                bit          op;
                int          lat, sel, exp_lat;
                string       tg;
                tg = $sformatf("w%0d_r%0d", W, RB);
                s_bus.ready_in   = 1'b0;
                s_bus.op_in      = 1'b0;
                s_bus.value_in   = '0;
                s_bus.modulus_in = '0;
                #1;
                while (!rst_n_sw) @(posedge clk);
                for (int n = 0; n < N_SWEEP; n++) begin
                    val = {$urandom, $urandom};
                    sel = $urandom_range(0, 9);
                    m   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd1 :
                          (sel < 5) ? 32'($urandom_range(2, 255)) : $urandom;
                    m   = 32'(m[W-1:0]);
                    op  = 1'($urandom_range(0, 1));
                    model(op, val, {32'd0, m}, W, eq, er, ee);
                    exp_lat = ee ? 2 : ST + 2;
                    @(negedge clk);
                    s_bus.ready_in   = 1'b1;
                    s_bus.op_in      = op;
                    s_bus.value_in   = val[2*W-1:0];
                    s_bus.modulus_in = m[W-1:0];
                    @(posedge clk);
                    #1;
                    lat = 1;
                    s_bus.ready_in = 1'b0;
                    while (!s_bus.valid_out && lat < ST + 10) begin
                        @(posedge clk);
                        #1;
                        lat++;
                    end
                    check_eq({tg, ".lat"},  64'(lat), 64'(exp_lat));
                    check_eq({tg, ".quot"}, 64'(s_bus.quotient_out), eq);
                    check_eq({tg, ".rem"},  64'(s_bus.remainder_out), er);
                    check_eq({tg, ".err"},  64'(s_bus.error_out), 64'(ee));
                end
                done = 1'b1;
            end
        end
    endgenerate

    logic all_done;
    assign all_done = g_sweep[0].done & g_sweep[1].done & g_sweep[2].done &
                      g_sweep[3].done & g_sweep[4].done & g_sweep[5].done;

    initial begin
        rst_n            = 1'b0;
        rst_n_sw         = 1'b0;
        m_bus.ready_in   = 1'b0;
        m_bus.op_in      = 1'b0;
        m_bus.value_in   = '0;
        m_bus.modulus_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.busy",  64'(m_bus.busy_out), 64'd0);
        check_eq("rst.valid", 64'(m_bus.valid_out), 64'd0);
        check_eq("rst.err",   64'(m_bus.error_out), 64'd0);
        check_eq("rst.rem",   64'(m_bus.remainder_out), 64'd0);
        check_eq("rst.quot",  64'(m_bus.quotient_out), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        rst_n_sw = 1'b1;

        run_main("div1000",    1'b0, 32'd1000,       16'd7,      0);
        check_eq("div1000.q_const", 64'(m_bus.quotient_out), 64'd142);
        run_main("mul300x500", 1'b1, 32'h01F4_012C,  16'd997,    0);
        check_eq("mul.r_const", 64'(m_bus.remainder_out), 64'd450);
        run_main("max_mffff",  1'b0, 32'hFFFF_FFFF, 16'hFFFF,    0);
        run_main("max_m1",     1'b0, 32'hFFFF_FFFF, 16'd1,       0);
        run_main("small",      1'b0, 32'd5,          16'd9,      0);
        run_main("mzero",      1'b0, 32'd1234,       16'd0,      0);
        run_main("after_zero", 1'b0, 32'd1000,       16'd7,      0);
        run_main("poke",       1'b0, 32'd123456,     16'd321,    6);
        back_to_back();
        reset_mid_run();
        run_main("post_rst",   1'b1, 32'h1234_ABCD, 16'hBEEF,    0);

        for (int c = 0; c < 20000 && !all_done; c++) @(posedge clk);
        check_eq("sweep.done", 64'(all_done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
